// File: rtl/instr_fetch_unit_pkg.sv
// rtl/instr_fetch_unit_pkg.sv - shared opcodes, fetch FSM encoding and reset PC
package instr_fetch_unit_pkg;

    localparam logic [5:0] OP_RTYPE = 6'd4;
    localparam logic [5:0] OP_ADDIU = 6'd12;
    localparam logic [5:0] OP_SUBIU = 6'd13;
    localparam logic [5:0] OP_SW    = 6'd16;
    localparam logic [5:0] OP_LW    = 6'd17;
    localparam logic [5:0] OP_BEQ   = 6'd19;
    localparam logic [5:0] OP_J     = 6'd28;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2
    } fetchState_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// rtl/instr_fetch_unit_if.sv - instruction memory req/ack bus
interface instr_fetch_unit_if #(
    parameter int ADDR_W = 32
) ();
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [31:0]       imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/instr_fetch_unit_next_pc_calc.sv
// rtl/instr_fetch_unit_next_pc_calc.sv - next PC selection for jump/branch/sequential
module next_pc_calc #(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic [25:0]       instr,
    input  logic              jump,
    input  logic              branch,
    input  logic              alu_zero,
    output logic [ADDR_W-1:0] next_pc
);
    logic [ADDR_W-1:0] pc4;
    logic [ADDR_W-1:0] branchOffset;

    assign pc4          = pc + ADDR_W'(4);
    assign branchOffset = {{(ADDR_W-18){instr[15]}}, instr[15:0], 2'b00};

    // Jump outranks branch; both additions wrap silently at 2^ADDR_W.
    always_comb begin
        next_pc = pc4;
        if (jump) begin
            next_pc = {pc4[ADDR_W-1:28], instr[25:0], 2'b00};
        end else if (branch && alu_zero) begin
            next_pc = pc4 + branchOffset;
        end
    end
endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - PC owner, imem fetch handshake and instruction hold stage
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int              ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
    input  logic                clk,
    input  logic                rst_n,
    instr_fetch_unit_if.master  imem,
    output logic                instr_valid,
    output logic [31:0]         instr,
    output logic [5:0]          opcode,
    output logic [ADDR_W-1:0]   pc,
    input  logic                id_ready,
    input  logic                jump,
    input  logic                branch,
    input  logic                alu_zero,
    output logic [31:0]         instr_count
);
    fetchState_t       state;
    logic              reqQ;
    logic              validQ;
    logic [ADDR_W-1:0] nextPc;

    next_pc_calc #(.ADDR_W(ADDR_W)) nextPcCalc (
        .pc       (pc),
        .instr    (instr[25:0]),
        .jump     (jump),
        .branch   (branch),
        .alu_zero (alu_zero),
        .next_pc  (nextPc)
    );

    assign imem.imem_req  = reqQ;
    assign imem.imem_addr = pc;
    assign instr_valid    = validQ;
    assign opcode         = instr[31:26];

    // req/valid are registered alongside the state so they track it exactly.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            pc          <= RESET_PC;
            instr       <= '0;
            instr_count <= '0;
            reqQ        <= 1'b0;
            validQ      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    state <= S_FETCH;
                    reqQ  <= 1'b1;
                end
                S_FETCH: begin
                    if (imem.imem_ack) begin
                        instr  <= imem.imem_rdata;
                        state  <= S_HOLD;
                        reqQ   <= 1'b0;
                        validQ <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (id_ready) begin
                        pc          <= nextPc;
                        instr_count <= instr_count + 32'd1;
                        state       <= S_FETCH;
                        reqQ        <= 1'b1;
                        validQ      <= 1'b0;
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    reqQ   <= 1'b0;
                    validQ <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - directed self-checking bench for instr_fetch_unit
module tb_instr_fetch_unit;
    import instr_fetch_unit_pkg::*;

    localparam logic [31:0] W0  = {OP_ADDIU, 26'h0012345};
    localparam logic [31:0] W1  = {OP_LW,    26'h0ABCDEF};
    localparam logic [31:0] W2  = {OP_SW,    26'h1234567};
    localparam logic [31:0] W3  = {OP_RTYPE, 26'h0000AAA};
    localparam logic [31:0] BEQ = {OP_BEQ, 10'd0, 16'hFFFE};
    localparam logic [31:0] JW  = {OP_J, 26'h0000010};
    localparam logic [31:0] J2  = {OP_J, 26'h0000040};

    logic        clk = 1'b0;
    logic        rstN;
    logic        instrValid, instrValid2;
    logic [31:0] instr, instr2;
    logic [5:0]  opcode, opcode2;
    logic [31:0] pc, pc2;
    logic        idReady, jump, branch, aluZero;
    logic        idReady2, jump2, branch2, aluZero2;
    logic [31:0] instrCount, instrCount2;

    int errors = 0;
    int checks = 0;
    int expCount = 0;

    always #5 clk = ~clk;

    instr_fetch_unit_if #(.ADDR_W(32)) imemBus ();
    instr_fetch_unit_if #(.ADDR_W(32)) imemBus2 ();

    instr_fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .rst_n       (rstN),
        .imem        (imemBus),
        .instr_valid (instrValid),
        .instr       (instr),
        .opcode      (opcode),
        .pc          (pc),
        .id_ready    (idReady),
        .jump        (jump),
        .branch      (branch),
        .alu_zero    (aluZero),
        .instr_count (instrCount)
    );

    instr_fetch_unit #(.ADDR_W(32), .RESET_PC(32'h2000_0000)) dut2 (
        .clk         (clk),
        .rst_n       (rstN),
        .imem        (imemBus2),
        .instr_valid (instrValid2),
        .instr       (instr2),
        .opcode      (opcode2),
        .pc          (pc2),
        .id_ready    (idReady2),
        .jump        (jump2),
        .branch      (branch2),
        .alu_zero    (aluZero2),
        .instr_count (instrCount2)
    );

    task automatic expectEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fetchWord(input logic [31:0] addr, input logic [31:0] word, input int waits);
        expectEq("fetch_req", 32'(imemBus.imem_req), 32'd1);
        expectEq("fetch_addr", imemBus.imem_addr, addr);
        for (int i = 0; i < waits; i++) begin
            tick();
            expectEq("wait_addr", imemBus.imem_addr, addr);
            expectEq("wait_valid", 32'(instrValid), 32'd0);
        end
        imemBus.imem_ack   = 1'b1;
        imemBus.imem_rdata = word;
        tick();
        imemBus.imem_ack   = 1'b0;
        imemBus.imem_rdata = 32'h0;
        expectEq("hold_valid", 32'(instrValid), 32'd1);
        expectEq("hold_instr", instr, word);
        expectEq("hold_opcode", 32'(opcode), 32'(word[31:26]));
        expectEq("hold_pc", pc, addr);
        expectEq("hold_req", 32'(imemBus.imem_req), 32'd0);
    endtask

    task automatic retire(input logic j, input logic b, input logic z);
        idReady = 1'b1;
        jump    = j;
        branch  = b;
        aluZero = z;
        tick();
        idReady = 1'b0;
        jump    = 1'b0;
        branch  = 1'b0;
        aluZero = 1'b0;
        expCount++;
        expectEq("retire_count", instrCount, 32'(expCount));
        expectEq("retire_valid", 32'(instrValid), 32'd0);
    endtask

    initial begin
        rstN = 1'b0;
        idReady = 1'b0; jump = 1'b0; branch = 1'b0; aluZero = 1'b0;
        idReady2 = 1'b0; jump2 = 1'b0; branch2 = 1'b0; aluZero2 = 1'b0;
        imemBus.imem_ack = 1'b0;  imemBus.imem_rdata = 32'h0;
        imemBus2.imem_ack = 1'b0; imemBus2.imem_rdata = 32'h0;

        tick();
        tick();
        expectEq("rst_req", 32'(imemBus.imem_req), 32'd0);
        expectEq("rst_valid", 32'(instrValid), 32'd0);
        expectEq("rst_opcode", 32'(opcode), 32'd0);
        expectEq("rst_pc", pc, 32'd0);
        expectEq("rst_count", instrCount, 32'd0);
        expectEq("rst_instr", instr, 32'd0);

        rstN = 1'b1;
        expectEq("bubble_req", 32'(imemBus.imem_req), 32'd0);
        tick();

        fetchWord(32'h00, W0, 0);
        retire(1'b0, 1'b0, 1'b0);
        fetchWord(32'h04, W1, 3);
        retire(1'b0, 1'b0, 1'b0);
        fetchWord(32'h08, W2, 0);

        for (int i = 0; i < 5; i++) begin
            imemBus.imem_ack   = 1'b1;
            imemBus.imem_rdata = 32'hDEAD_BEEF;
            jump = 1'b1;
            tick();
            expectEq("stall_instr", instr, W2);
            expectEq("stall_pc", pc, 32'h08);
            expectEq("stall_count", instrCount, 32'(expCount));
            expectEq("stall_valid", 32'(instrValid), 32'd1);
        end
        imemBus.imem_ack   = 1'b0;
        imemBus.imem_rdata = 32'h0;
        jump = 1'b0;
        retire(1'b0, 1'b0, 1'b0);

        fetchWord(32'h0C, W3, 0);
        retire(1'b0, 1'b0, 1'b0);
        fetchWord(32'h10, BEQ, 0);
        retire(1'b0, 1'b1, 1'b1);
        fetchWord(32'h0C, W3, 0);
        retire(1'b0, 1'b0, 1'b0);
        fetchWord(32'h10, BEQ, 0);
        retire(1'b0, 1'b1, 1'b0);
        fetchWord(32'h14, JW, 0);
        retire(1'b1, 1'b0, 1'b0);

        expectEq("jmp_addr", imemBus.imem_addr, 32'h40);
        tick();
        expectEq("mid_req", 32'(imemBus.imem_req), 32'd1);
        rstN = 1'b0;
        imemBus.imem_ack   = 1'b1;
        imemBus.imem_rdata = 32'hDEAD_BEEF;
        tick();
        imemBus.imem_ack   = 1'b0;
        imemBus.imem_rdata = 32'h0;
        expectEq("midrst_req", 32'(imemBus.imem_req), 32'd0);
        expectEq("midrst_pc", pc, 32'd0);
        expectEq("midrst_count", instrCount, 32'd0);
        expectEq("midrst_valid", 32'(instrValid), 32'd0);
        expectEq("midrst_opcode", 32'(opcode), 32'd0);
        rstN = 1'b1;
        expCount = 0;
        tick();
        fetchWord(32'h00, W0, 1);
        retire(1'b0, 1'b0, 1'b0);

        expectEq("j2_req", 32'(imemBus2.imem_req), 32'd1);
        expectEq("j2_addr", imemBus2.imem_addr, 32'h2000_0000);
        imemBus2.imem_ack   = 1'b1;
        imemBus2.imem_rdata = J2;
        tick();
        imemBus2.imem_ack   = 1'b0;
        expectEq("j2_valid", 32'(instrValid2), 32'd1);
        expectEq("j2_pc", pc2, 32'h2000_0000);
        idReady2 = 1'b1; jump2 = 1'b1; branch2 = 1'b1; aluZero2 = 1'b1;
        tick();
        idReady2 = 1'b0; jump2 = 1'b0; branch2 = 1'b0; aluZero2 = 1'b0;
        expectEq("j2_target", imemBus2.imem_addr, 32'h2000_0100);
        expectEq("j2_req_next", 32'(imemBus2.imem_req), 32'd1);
        expectEq("j2_count", instrCount2, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Supplies the 6-bit OpCode and full instruction word to the main-control decoder.
- Owns the PC and runs a req/ack handshake with instruction memory.
- Holds each fetched instruction until the downstream stage accepts it.
- Consumes the decoder's Jump/Branch outputs and the ALU zero flag to pick the next PC.

Parameters:
- ADDR_W, 32, PC/instruction-address width (byte address, word aligned).
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  ADDR_W  fetch address; equals pc whenever imem_req=1.
- imem_ack  in  1  memory returns data this cycle.
- imem_rdata  in  32  instruction word, valid when imem_ack=1.
- instr_valid  out  1  instr/opcode hold a fetched instruction.
- instr  out  32  latched instruction word.
- opcode  out  6  instr[31:26], driven to the control decoder.
- pc  out  ADDR_W  address of the held instruction.
- id_ready  in  1  downstream consumes the held instruction this cycle.
- jump  in  1  decoder Jump for the held instruction.
- branch  in  1  decoder Branch for the held instruction.
- alu_zero  in  1  ALU zero flag for the held instruction.
- instr_count  out  32  number of instructions retired (accepted).

Behaviour:
- Reset (rst_n=0 at a clk edge, from any state, including mid-handshake):
  - state=S_IDLE, pc=RESET_PC, instr=0, instr_count=0.
  - Next cycle: imem_req=0, instr_valid=0, opcode=0.
- FSM states: S_IDLE, S_FETCH, S_HOLD.
  - imem_req=1 only in S_FETCH.
  - instr_valid=1 only in S_HOLD.
  - S_IDLE -> S_FETCH unconditionally on the next edge, so there is 1 bubble cycle after reset release.
  - S_FETCH: hold imem_addr=pc stable until imem_ack. On imem_ack=1: instr<=imem_rdata, -> S_HOLD. Fetch latency is 1 cycle + memory wait states.
  - S_HOLD: instr, opcode and pc stay stable until id_ready=1. On id_ready=1: pc<=next_pc, instr_count<=instr_count+1 (wraps at 2^32), -> S_FETCH.
- next_pc (evaluated only at the S_HOLD accept edge):
  - pc4 = pc+4, modulo 2^ADDR_W.
  - jump=1: {pc4[ADDR_W-1:28], instr[25:0], 2'b00}. Jump has priority over branch when both are asserted.
  - else branch=1 and alu_zero=1: pc4 + (sign_extend(instr[15:0]) << 2), modulo 2^ADDR_W, wraps silently.
  - else pc4.
- jump, branch and alu_zero are ignored outside S_HOLD and when id_ready=0.
- imem_ack outside S_FETCH is ignored; imem_rdata is not latched.
- pc[1:0] is always 0; targets are word-aligned by construction.
- imem_ack and id_ready in the same cycle: only the one relevant to the current state acts.
- No instruction is ever dropped or duplicated: each ack produces exactly one S_HOLD period, and each accept produces exactly one retire.

Decomposition:
- Shared package / include file holds:
  - opcode constants OP_RTYPE=6'd4, OP_ADDIU=6'd12, OP_SUBIU=6'd13, OP_SW=6'd16, OP_LW=6'd17, OP_BEQ=6'd19, OP_J=6'd28;
  - FSM state encoding (2 bits);
  - RESET_PC default.
- One natural sub-module: next_pc_calc (combinational; inputs pc, instr, jump, branch, alu_zero; output next_pc). The rest stays in instr_fetch_unit.

Test Plan:
- Reset release, imem_ack=1 immediately, id_ready=1:
  - cycle 1 after release: imem_req=0;
  - cycle 2: imem_req=1, imem_addr=0;
  - cycle 3: instr_valid=1.
  - Addresses then go 0, 4, 8; instr_count increments per accept.
- Memory wait states: imem_ack delayed 3 cycles -> imem_addr held constant, instr_valid=0 throughout, instr equals the acked word.
- Stall: id_ready=0 for 5 cycles while in S_HOLD -> instr, opcode, pc and instr_count unchanged.
  - Stray imem_ack=1 with rdata=32'hDEAD_BEEF during the stall is ignored.
- Branch taken at pc=0x10, instr[15:0]=16'hFFFE, branch=1, alu_zero=1 -> next fetch addr 0x0C.
  - Same instruction with alu_zero=0 -> next fetch addr 0x14.
- Jump at pc=0x2000_0000, instr[25:0]=26'h0000040, jump=1 and branch=1 -> next fetch addr 0x2000_0100 (jump wins).
- Reset mid-handshake: rst_n=0 while in S_FETCH at addr 0x40 -> next cycle imem_req=0, pc=0, instr_count=0; fetch restarts at 0.
